// File: rtl/clk_rate_det_pkg.sv
// Shared types and rate-bin constants for the clk_meas frequency detector.
// Bins assume a 1000-cycle gate window at 50 MHz.
package clk_rate_det_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    R1M     = 3'd1,
    R8M3    = 3'd2,
    R12M5   = 3'd3,
    UNKNOWN = 3'd7
  } rate_e;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_e;

  localparam logic [COUNT_W-1:0] NONE_LO  = 16'd0;
  localparam logic [COUNT_W-1:0] NONE_HI  = 16'd2;
  localparam logic [COUNT_W-1:0] R1M_LO   = 16'd18;
  localparam logic [COUNT_W-1:0] R1M_HI   = 16'd22;
  localparam logic [COUNT_W-1:0] R8M3_LO  = 16'd160;
  localparam logic [COUNT_W-1:0] R8M3_HI  = 16'd172;
  localparam logic [COUNT_W-1:0] R12M5_LO = 16'd245;
  localparam logic [COUNT_W-1:0] R12M5_HI = 16'd255;

  function automatic rate_e classify(input logic [COUNT_W-1:0] count);
    if (count >= NONE_LO && count <= NONE_HI)        return NONE;
    else if (count >= R1M_LO && count <= R1M_HI)     return R1M;
    else if (count >= R8M3_LO && count <= R8M3_HI)   return R8M3;
    else if (count >= R12M5_LO && count <= R12M5_HI) return R12M5;
    else                                             return UNKNOWN;
  endfunction

endpackage

// File: rtl/clk_rate_detector_sync_edge.sv
// Synchroniser chain plus history flop; emits a one-cycle pulse per rising
// edge of an asynchronous input. SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_rate_detector.sv
// Counts clk_meas rising edges over a GATE_CYCLES window and bins the result.
// Define CLK_RATE_DET_LOSS_EN to build the loss-of-clock idle counter.
module clk_rate_detector
  import clk_rate_det_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_CYCLES = 256
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clk_meas,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic               meas_valid,
  output logic [COUNT_W-1:0] edge_count,
  output logic [2:0]         rate_code,
  output logic               loss_of_clock
);

  localparam int CYC_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CYC_W-1:0] ARM_LAST  = CYC_W'(SYNC_STAGES);
  localparam logic [CYC_W-1:0] GATE_LAST = CYC_W'(GATE_CYCLES - 1);

  state_e             state;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_cnt_next;
  logic               rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .async_in  (clk_meas),
    .rise_pulse(rise)
  );

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    edge_cnt_next = edge_cnt;
    if (rise && edge_cnt != '1) edge_cnt_next = edge_cnt + 1'b1;
  end

  // The final gate cycle's edge is folded in via edge_cnt_next, so results publish on entry to DONE.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      edge_cnt   <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      edge_count <= '0;
      rate_code  <= NONE;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            cyc_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ARM: begin
          if (cyc_cnt == ARM_LAST) begin
            state    <= GATE;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        GATE: begin
          edge_cnt <= edge_cnt_next;
          if (cyc_cnt == GATE_LAST) begin
            state      <= DONE;
            edge_count <= edge_cnt_next;
            rate_code  <= classify(edge_cnt_next);
            meas_valid <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DONE: begin
          cyc_cnt  <= '0;
          edge_cnt <= '0;
          if (continuous) begin
            state <= GATE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_RATE_DET_LOSS_EN
  localparam int IDLE_W = $clog2(LOSS_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      idle_cnt      <= '0;
      loss_of_clock <= 1'b0;
    end else if (rise) begin
      idle_cnt      <= '0;
      loss_of_clock <= 1'b0;
    end else if (idle_cnt != IDLE_W'(LOSS_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_W'(LOSS_CYCLES - 1)) loss_of_clock <= 1'b1;
    end
  end
`else
  assign loss_of_clock = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rate_detector.sv
// Directed bench for clk_rate_detector: table of clk_meas rates plus
// hand-written continuous, reset-abort and start-while-busy sequences.
module tb_clk_rate_detector;
  import clk_rate_det_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        clk_meas;
  logic        start;
  logic        continuous;
  logic        busy;
  logic        meas_valid;
  logic [15:0] edge_count;
  logic [2:0]  rate_code;
  logic        loss_of_clock;

  int half_per;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int half;
    int cnt_lo;
    int cnt_hi;
    int rate;
  } vec_t;

  vec_t vecs[5];

  clk_rate_detector dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .clk_meas     (clk_meas),
    .start        (start),
    .continuous   (continuous),
    .busy         (busy),
    .meas_valid   (meas_valid),
    .edge_count   (edge_count),
    .rate_code    (rate_code),
    .loss_of_clock(loss_of_clock)
  );

  always #10 clk_in = ~clk_in;

  // clk_meas toggles every half_per clk_in cycles; half_per 0 holds it low.
  initial begin
    int ph;
    ph = 0;
    clk_meas = 1'b0;
    forever begin
      @(negedge clk_in);
      if (half_per == 0) begin
        clk_meas = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half_per) begin
          ph = 0;
          clk_meas = ~clk_meas;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Called at a negedge; pulses start and returns cycles until meas_valid.
  task automatic run_meas(input int restart_at, output int lat);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    lat = 1;
    while (!meas_valid && lat < 3000) begin
      @(negedge clk_in);
      lat++;
      start = (lat == restart_at);
    end
    start = 1'b0;
  endtask

  // Waits for the next meas_valid after the current cycle, bounded.
  task automatic wait_next(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!meas_valid && n < 3000);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk_in);
      if (meas_valid) pulses++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int pulses;

    vecs[0] = '{25, 20, 20, int'(R1M)};
    vecs[1] = '{3, 166, 167, int'(R8M3)};
    vecs[2] = '{5, 100, 100, int'(UNKNOWN)};
    vecs[3] = '{0, 0, 0, int'(NONE)};
    vecs[4] = '{2, 250, 250, int'(R12M5)};

    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    half_per = 0;
    repeat (3) @(negedge clk_in);
    check("reset busy", int'(busy), 0);
    check("reset meas_valid", int'(meas_valid), 0);
    check("reset edge_count", int'(edge_count), 0);
    check("reset rate_code", int'(rate_code), 0);
    check("reset loss", int'(loss_of_clock), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    for (int i = 0; i < 5; i++) begin
      half_per = vecs[i].half;
      repeat (20) @(negedge clk_in);
      run_meas(0, lat);
      check($sformatf("vec%0d latency", i), lat, 1004);
      check_range($sformatf("vec%0d edge_count", i), int'(edge_count), vecs[i].cnt_lo, vecs[i].cnt_hi);
      check($sformatf("vec%0d rate_code", i), int'(rate_code), vecs[i].rate);
      check($sformatf("vec%0d busy in DONE", i), int'(busy), 1);
      @(negedge clk_in);
      check($sformatf("vec%0d busy after", i), int'(busy), 0);
      check($sformatf("vec%0d valid one-shot", i), int'(meas_valid), 0);
      repeat (5) @(negedge clk_in);
      check($sformatf("vec%0d hold count", i), int'(edge_count) >= vecs[i].cnt_lo && int'(edge_count) <= vecs[i].cnt_hi, 1);
    end

    // Continuous back-to-back gates at period 4, then drop continuous mid-gate.
    half_per = 2;
    continuous = 1'b1;
    repeat (10) @(negedge clk_in);
    run_meas(0, lat);
    check("cont first latency", lat, 1004);
    check("cont first count", int'(edge_count), 250);
    for (int k = 0; k < 2; k++) begin
      wait_next(n);
      check($sformatf("cont interval %0d", k), n, 1001);
      check($sformatf("cont count %0d", k), int'(edge_count), 250);
      check($sformatf("cont rate %0d", k), int'(rate_code), int'(R12M5));
      check($sformatf("cont busy %0d", k), int'(busy), 1);
    end
    repeat (500) @(negedge clk_in);
    continuous = 1'b0;
    wait_next(n);
    check("cont drop interval", n, 501);
    check("cont drop count", int'(edge_count), 250);
    @(negedge clk_in);
    check("cont drop busy", int'(busy), 0);
    count_pulses(1100, pulses);
    check("cont drop no more results", pulses, 0);

    // Loss-of-clock: hold clk_meas low, then restart it.
    half_per = 0;
    repeat (300) @(negedge clk_in);
`ifdef CLK_RATE_DET_LOSS_EN
    check("loss set", int'(loss_of_clock), 1);
`else
    check("loss tied low", int'(loss_of_clock), 0);
`endif
    half_per = 2;
    repeat (8) @(negedge clk_in);
    check("loss cleared", int'(loss_of_clock), 0);

    // Reset aborts a gate in progress and clears published results.
    half_per = 25;
    repeat (10) @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (503) @(negedge clk_in);
    rst = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort meas_valid", int'(meas_valid), 0);
    check("abort edge_count", int'(edge_count), 0);
    check("abort rate_code", int'(rate_code), 0);
    check("abort loss", int'(loss_of_clock), 0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    count_pulses(1100, pulses);
    check("abort no result", pulses, 0);
    check("abort idle busy", int'(busy), 0);
    run_meas(0, lat);
    check("post-abort latency", lat, 1004);
    check("post-abort count", int'(edge_count), 20);
    check("post-abort rate", int'(rate_code), int'(R1M));

    // Start while busy is ignored: same latency, no extra result.
    half_per = 5;
    repeat (20) @(negedge clk_in);
    run_meas(500, lat);
    check("restart latency", lat, 1004);
    check("restart count", int'(edge_count), 100);
    check("restart rate", int'(rate_code), int'(UNKNOWN));
    count_pulses(1100, pulses);
    check("restart no extra result", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
